// File: rtl/vproc_axil_bridge.sv
// Bridges single-word VProc bus accesses onto an AXI4-Lite master port.
// Optional response watchdog enabled by defining VPROC_AXIL_TIMEOUT_EN.
module vproc_axil_bridge #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter logic [2:0]  AXI_PROT       = 3'b000,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [31:0]           Addr,
    input  logic                  WE,
    input  logic                  RD,
    input  logic [31:0]           DataOut,
    output logic [31:0]           DataIn,
    output logic                  WRAck,
    output logic                  RDAck,
    output logic                  RespErr,
`ifdef VPROC_AXIL_TIMEOUT_EN
    output logic                  TimeoutErr,
`endif
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic [2:0]            AWPROT,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [31:0]           WDATA,
    output logic [3:0]            WSTRB,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic [2:0]            ARPROT,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [31:0]           RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RVALID,
    output logic                  RREADY
);

    typedef enum logic [2:0] {StIdle, StWrReq, StWrResp, StRdReq, StRdResp, StAck} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [31:0]             wdata_q, wdata_d, datain_q, datain_d;
    logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic                    arvalid_q, arvalid_d, rready_q, rready_d;
    logic                    wrack_q, wrack_d, rdack_q, rdack_d, resp_err_q, resp_err_d;

`ifdef VPROC_AXIL_TIMEOUT_EN
    localparam int unsigned     TimerW    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);
    logic [TimerW-1:0] timer_q, timer_d;
    logic              timeout_err_q, timeout_err_d;
    logic              busy;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^{ERR_RDATA, TIMEOUT_CYCLES};
`endif

    always_comb begin
        state_d    = state_q;
        awaddr_d   = awaddr_q;
        araddr_d   = araddr_q;
        wdata_d    = wdata_q;
        datain_d   = datain_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        wrack_d    = 1'b0;
        rdack_d    = 1'b0;
        resp_err_d = resp_err_q;

        case (state_q)
            StIdle: begin
                if (WE) begin
                    awaddr_d  = Addr[ADDR_WIDTH-1:0];
                    wdata_d   = DataOut;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = StWrReq;
                end else if (RD) begin
                    araddr_d  = Addr[ADDR_WIDTH-1:0];
                    arvalid_d = 1'b1;
                    state_d   = StRdReq;
                end
            end
            StWrReq: begin
                // A channel is finished once its VALID has been dropped.
                awvalid_d = awvalid_q & ~AWREADY;
                wvalid_d  = wvalid_q & ~WREADY;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = StWrResp;
                end
            end
            StWrResp: begin
                if (BVALID) begin
                    bready_d = 1'b0;
                    wrack_d  = 1'b1;
                    if (BRESP != 2'b00) resp_err_d = 1'b1;
                    state_d  = StAck;
                end
            end
            StRdReq: begin
                if (ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = StRdResp;
                end
            end
            StRdResp: begin
                if (RVALID) begin
                    datain_d = RDATA;
                    rready_d = 1'b0;
                    rdack_d  = 1'b1;
                    if (RRESP != 2'b00) resp_err_d = 1'b1;
                    state_d  = StAck;
                end
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase

`ifdef VPROC_AXIL_TIMEOUT_EN
        timer_d       = timer_q;
        timeout_err_d = timeout_err_q;
        busy = (state_q == StWrReq) || (state_q == StWrResp) ||
               (state_q == StRdReq) || (state_q == StRdResp);
        if (state_q == StIdle && state_d != StIdle) begin
            timer_d = '0;
        end else if (busy) begin
            timer_d = timer_q + 1'b1;
        end
        // A response arriving on the expiry cycle still completes normally.
        if (busy && timer_q == TimerLast && state_d != StAck) begin
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            bready_d      = 1'b0;
            arvalid_d     = 1'b0;
            rready_d      = 1'b0;
            timeout_err_d = 1'b1;
            state_d       = StAck;
            if (state_q == StWrReq || state_q == StWrResp) begin
                wrack_d = 1'b1;
            end else begin
                rdack_d  = 1'b1;
                datain_d = ERR_RDATA;
            end
        end
`endif
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= StIdle;
            awaddr_q   <= '0;
            araddr_q   <= '0;
            wdata_q    <= '0;
            datain_q   <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            wrack_q    <= 1'b0;
            rdack_q    <= 1'b0;
            resp_err_q <= 1'b0;
`ifdef VPROC_AXIL_TIMEOUT_EN
            timer_q       <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            awaddr_q   <= awaddr_d;
            araddr_q   <= araddr_d;
            wdata_q    <= wdata_d;
            datain_q   <= datain_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            wrack_q    <= wrack_d;
            rdack_q    <= rdack_d;
            resp_err_q <= resp_err_d;
`ifdef VPROC_AXIL_TIMEOUT_EN
            timer_q       <= timer_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign DataIn  = datain_q;
    assign WRAck   = wrack_q;
    assign RDAck   = rdack_q;
    assign RespErr = resp_err_q;
`ifdef VPROC_AXIL_TIMEOUT_EN
    assign TimeoutErr = timeout_err_q;
`endif
    assign AWADDR  = awaddr_q;
    assign AWPROT  = AXI_PROT;
    assign AWVALID = awvalid_q;
    assign WDATA   = wdata_q;
    assign WSTRB   = 4'hF;
    assign WVALID  = wvalid_q;
    assign BREADY  = bready_q;
    assign ARADDR  = araddr_q;
    assign ARPROT  = AXI_PROT;
    assign ARVALID = arvalid_q;
    assign RREADY  = rready_q;

endmodule
